risk_mem: RTL and testbench
===========================

// Module: risk_mem
// PURPOSE
//  Memory responder for the rv32i core's two bus ports: a read-only instruction
//  port (mem_i_*) and a read/write data port (mem_d_*) backed by one shared
//  word array. Sits beside the core in the SoC/testbench top; answers every
//  strobe with optional wait states signalled on the *busy outputs.
// PARAMETERS
//  ADDR_WIDTH  12   word-address bits; depth = 2**ADDR_WIDTH 32-bit words
//  I_WAIT      0    extra wait cycles per instruction read (0..15)
//  D_WAIT      0    extra wait cycles per data read or write (0..15)
//  INIT_FILE   ""   $readmemh image loaded at time 0 when non-empty
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst_n        in   1   asynchronous reset, active low
//  mem_i_addr   in   32  instruction byte address
//  mem_i_rstrb  in   1   instruction read request
//  mem_i_rdata  out  32  instruction read data
//  mem_i_rbusy  out  1   instruction read in progress
//  mem_d_addr   in   32  data byte address
//  mem_d_wdata  in   32  write data, lanes already replicated by the core
//  mem_d_wmask  in   4   byte-lane write enables (bit n = wdata[8n+7:8n])
//  mem_d_wstrb  in   1   data write request
//  mem_d_rstrb  in   1   data read request
//  mem_d_rdata  out  32  data read data (full word, core extracts lanes)
//  mem_d_rbusy  out  1   data read in progress
//  mem_d_wbusy  out  1   data write in progress
//  mem_d_err    out  1   one-cycle pulse: out-of-range access or r/w collision
// BEHAVIOUR
//  - Reset (rst_n low, async): all outputs 0, both port FSMs IDLE, wait
//    counters 0, latched addr/data/mask cleared. Array contents NOT reset.
//    Reset during WAIT abandons the transaction; a pending write is not committed.
//  - Word index = addr[ADDR_WIDTH+1:2]; addr[1:0] ignored. addr[31:ADDR_WIDTH+2]
//    nonzero = out of range: read returns 32'h0, write dropped, mem_d_err pulses
//    the cycle after the strobe (instruction port: read returns 0, no err).
//  - Each port: FSM IDLE -> WAIT -> IDLE. Strobes sampled only in IDLE; strobes
//    while busy are ignored (not queued).
//  - Read, strobe sampled at edge T0, N = port WAIT:
//    N=0: rdata updated at T0, valid cycle T0+1, busy stays 0 (back-to-back
//    reads every cycle; mem_i_rstrb tied high gives rdata = mem[addr of prev cycle]).
//    N>0: address latched at T0; rbusy=1 cycles T0+1..T0+N; at end of cycle
//    T0+N rdata loads mem[latched addr], rbusy->0; data valid from T0+N+1.
//  - rdata holds its last value until the next completed read.
//  - Write, wstrb sampled at T0: N=0 commit masked bytes at T0, wbusy stays 0.
//    N>0: addr/wdata/wmask latched at T0, wbusy=1 cycles T0+1..T0+N, commit at
//    end of T0+N, wbusy->0. wmask=0000 is a legal no-op taking the same cycles.
//  - rstrb and wstrb together in IDLE: write serviced, read dropped, mem_d_err
//    pulses cycle T0+1, rbusy stays 0, mem_d_rdata unchanged.
//  - Data write and instruction read of same word committing on the same edge:
//    instruction port returns the pre-write word (read-before-write); data-port
//    read issued after write completes returns the new word.
//  - Ports fully independent; no arbitration stalls between them.
// TESTING
//  1. I_WAIT=D_WAIT=0, INIT mem[0..3]=1,2,3,4; mem_i_rstrb=1, addr 0,4,8 on
//     consecutive cycles -> mem_i_rdata 1,2,3 one cycle later each, rbusy always 0.
//  2. Write 32'hAABBCCDD mask 1111 to 0x10, then wdata 32'h11111111 mask 0010
//     -> read of 0x10 returns 32'hAABB11DD.
//  3. D_WAIT=3: rstrb at 0x10 at T0 -> rbusy high T0+1..T0+3, rdata valid T0+4;
//     a second rstrb at T0+2 is ignored.
//  4. Simultaneous wstrb+rstrb, addr 0x20, wdata 5 -> mem[8]=5, mem_d_err one
//     pulse, rdata unchanged; write to 0x0010_0000 (ADDR_WIDTH=12) -> err, no write.
//  5. D_WAIT=4: write 0x30 value 9, assert rst_n low at T0+2 -> all busy/err 0
//     immediately; later read of 0x30 returns old value.
//  6. Same-edge data write 7 to 0x40 and instruction read of 0x40 -> mem_i_rdata
//     old word; next instruction read returns 7.

Source files
------------

// File: rtl/risk_mem.sv
// Dual-port memory responder for the rv32i core: read-only instruction port and
// read/write data port over one shared word array, with optional wait states.
module risk_mem #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned I_WAIT     = 0,
    parameter int unsigned D_WAIT     = 0,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_i_addr,
    input  logic        mem_i_rstrb,
    output logic [31:0] mem_i_rdata,
    output logic        mem_i_rbusy,
    input  logic [31:0] mem_d_addr,
    input  logic [31:0] mem_d_wdata,
    input  logic [3:0]  mem_d_wmask,
    input  logic        mem_d_wstrb,
    input  logic        mem_d_rstrb,
    output logic [31:0] mem_d_rdata,
    output logic        mem_d_rbusy,
    output logic        mem_d_wbusy,
    output logic        mem_d_err
);

    typedef enum logic {I_ST_IDLE, I_ST_WAIT} i_state_t;
    typedef enum logic [1:0] {D_ST_IDLE, D_ST_RD, D_ST_WR} d_state_t;

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{mem_i_addr[1:0], mem_d_addr[1:0]};

    // ---------------- instruction port ----------------
    i_state_t               i_state, i_next;
    logic [ADDR_WIDTH-1:0]  i_req_idx, i_idx, i_use_idx;
    logic                   i_req_oor, i_oor, i_use_oor;
    logic [3:0]             i_cnt;
    logic                   i_fire, i_latch;

    assign i_req_idx   = mem_i_addr[ADDR_WIDTH+1:2];
    assign i_req_oor   = |mem_i_addr[31:ADDR_WIDTH+2];
    assign i_use_idx   = (i_state == I_ST_IDLE) ? i_req_idx : i_idx;
    assign i_use_oor   = (i_state == I_ST_IDLE) ? i_req_oor : i_oor;
    assign mem_i_rbusy = (i_state == I_ST_WAIT);

    always_comb begin
        i_next  = i_state;
        i_fire  = 1'b0;
        i_latch = 1'b0;
        case (i_state)
            I_ST_IDLE: begin
                if (mem_i_rstrb) begin
                    if (I_WAIT == 0) begin
                        i_fire = 1'b1;
                    end else begin
                        i_latch = 1'b1;
                        i_next  = I_ST_WAIT;
                    end
                end
            end
            I_ST_WAIT: begin
                if (i_cnt == '0) begin
                    i_fire = 1'b1;
                    i_next = I_ST_IDLE;
                end
            end
            default: i_next = I_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) i_state <= I_ST_IDLE;
        else        i_state <= i_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_idx       <= '0;
            i_oor       <= 1'b0;
            i_cnt       <= '0;
            mem_i_rdata <= '0;
        end else begin
            if (i_latch) begin
                i_idx <= i_req_idx;
                i_oor <= i_req_oor;
                i_cnt <= 4'(I_WAIT - 1);
            end else if (i_cnt != '0) begin
                i_cnt <= i_cnt - 1'b1;
            end
            // Nonblocking read sees the pre-write word when a data write commits on the same edge.
            if (i_fire) mem_i_rdata <= i_use_oor ? '0 : mem[i_use_idx];
        end
    end

    // ---------------- data port ----------------
    d_state_t               d_state, d_next;
    logic [ADDR_WIDTH-1:0]  d_req_idx, d_idx, d_use_idx;
    logic                   d_req_oor, d_oor, d_use_oor;
    logic [31:0]            d_wdata, d_use_wdata;
    logic [3:0]             d_wmask, d_use_wmask;
    logic [3:0]             d_cnt;
    logic                   d_rd_fire, d_wr_fire, d_latch, d_err_set;

    assign d_req_idx   = mem_d_addr[ADDR_WIDTH+1:2];
    assign d_req_oor   = |mem_d_addr[31:ADDR_WIDTH+2];
    assign d_use_idx   = (d_state == D_ST_IDLE) ? d_req_idx   : d_idx;
    assign d_use_oor   = (d_state == D_ST_IDLE) ? d_req_oor   : d_oor;
    assign d_use_wdata = (d_state == D_ST_IDLE) ? mem_d_wdata : d_wdata;
    assign d_use_wmask = (d_state == D_ST_IDLE) ? mem_d_wmask : d_wmask;
    assign mem_d_rbusy = (d_state == D_ST_RD);
    assign mem_d_wbusy = (d_state == D_ST_WR);

    always_comb begin
        d_next    = d_state;
        d_rd_fire = 1'b0;
        d_wr_fire = 1'b0;
        d_latch   = 1'b0;
        d_err_set = 1'b0;
        case (d_state)
            D_ST_IDLE: begin
                // A write wins over a simultaneous read; the read is dropped and flagged.
                if (mem_d_wstrb) begin
                    d_err_set = mem_d_rstrb | d_req_oor;
                    if (D_WAIT == 0) begin
                        d_wr_fire = 1'b1;
                    end else begin
                        d_latch = 1'b1;
                        d_next  = D_ST_WR;
                    end
                end else if (mem_d_rstrb) begin
                    d_err_set = d_req_oor;
                    if (D_WAIT == 0) begin
                        d_rd_fire = 1'b1;
                    end else begin
                        d_latch = 1'b1;
                        d_next  = D_ST_RD;
                    end
                end
            end
            D_ST_RD: begin
                if (d_cnt == '0) begin
                    d_rd_fire = 1'b1;
                    d_next    = D_ST_IDLE;
                end
            end
            D_ST_WR: begin
                if (d_cnt == '0) begin
                    d_wr_fire = 1'b1;
                    d_next    = D_ST_IDLE;
                end
            end
            default: d_next = D_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_state <= D_ST_IDLE;
        else        d_state <= d_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_idx       <= '0;
            d_oor       <= 1'b0;
            d_wdata     <= '0;
            d_wmask     <= '0;
            d_cnt       <= '0;
            mem_d_rdata <= '0;
            mem_d_err   <= 1'b0;
        end else begin
            mem_d_err <= d_err_set;
            if (d_latch) begin
                d_idx   <= d_req_idx;
                d_oor   <= d_req_oor;
                d_wdata <= mem_d_wdata;
                d_wmask <= mem_d_wmask;
                d_cnt   <= 4'(D_WAIT - 1);
            end else if (d_cnt != '0) begin
                d_cnt <= d_cnt - 1'b1;
            end
            if (d_rd_fire) mem_d_rdata <= d_use_oor ? '0 : mem[d_use_idx];
            if (d_wr_fire && !d_use_oor) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (d_use_wmask[b]) mem[d_use_idx][8*b +: 8] <= d_use_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_risk_mem.sv
// Directed bench for risk_mem: a zero-wait instance and a wait-state instance
// (I_WAIT=1, D_WAIT=3) exercised with hand-computed expectations.
module tb_risk_mem;

    logic        clk = 1'b0;
    logic        rst_n0, rst_n1;

    logic [31:0] i0_addr, i0_rdata, d0_addr, d0_wdata, d0_rdata;
    logic        i0_rstrb, i0_rbusy, d0_wstrb, d0_rstrb, d0_rbusy, d0_wbusy, d0_err;
    logic [3:0]  d0_wmask;

    logic [31:0] i1_addr, i1_rdata, d1_addr, d1_wdata, d1_rdata;
    logic        i1_rstrb, i1_rbusy, d1_wstrb, d1_rstrb, d1_rbusy, d1_wbusy, d1_err;
    logic [3:0]  d1_wmask;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    risk_mem #(.ADDR_WIDTH(12), .I_WAIT(0), .D_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n0),
        .mem_i_addr(i0_addr), .mem_i_rstrb(i0_rstrb), .mem_i_rdata(i0_rdata), .mem_i_rbusy(i0_rbusy),
        .mem_d_addr(d0_addr), .mem_d_wdata(d0_wdata), .mem_d_wmask(d0_wmask),
        .mem_d_wstrb(d0_wstrb), .mem_d_rstrb(d0_rstrb), .mem_d_rdata(d0_rdata),
        .mem_d_rbusy(d0_rbusy), .mem_d_wbusy(d0_wbusy), .mem_d_err(d0_err)
    );

    risk_mem #(.ADDR_WIDTH(12), .I_WAIT(1), .D_WAIT(3)) dut1 (
        .clk(clk), .rst_n(rst_n1),
        .mem_i_addr(i1_addr), .mem_i_rstrb(i1_rstrb), .mem_i_rdata(i1_rdata), .mem_i_rbusy(i1_rbusy),
        .mem_d_addr(d1_addr), .mem_d_wdata(d1_wdata), .mem_d_wmask(d1_wmask),
        .mem_d_wstrb(d1_wstrb), .mem_d_rstrb(d1_rstrb), .mem_d_rdata(d1_rdata),
        .mem_d_rbusy(d1_rbusy), .mem_d_wbusy(d1_wbusy), .mem_d_err(d1_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic d0_write(input logic [31:0] a, input logic [31:0] w, input logic [3:0] m);
        d0_addr = a; d0_wdata = w; d0_wmask = m; d0_wstrb = 1'b1;
        @(negedge clk);
        d0_wstrb = 1'b0;
    endtask

    task automatic d0_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        d0_addr = a; d0_rstrb = 1'b1;
        @(negedge clk);
        d0_rstrb = 1'b0;
        check(tag, d0_rdata, exp);
        check({tag, "_rbusy"}, {31'b0, d0_rbusy}, 32'd0);
    endtask

    task automatic d1_write(input logic [31:0] a, input logic [31:0] w);
        d1_addr = a; d1_wdata = w; d1_wmask = 4'hF; d1_wstrb = 1'b1;
        @(negedge clk);
        d1_wstrb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("d1_wbusy_hi", {31'b0, d1_wbusy}, 32'd1);
            @(negedge clk);
        end
        check("d1_wbusy_lo", {31'b0, d1_wbusy}, 32'd0);
    endtask

    task automatic d1_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        d1_addr = a; d1_rstrb = 1'b1;
        @(negedge clk);
        d1_rstrb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check({tag, "_rbusy_hi"}, {31'b0, d1_rbusy}, 32'd1);
            @(negedge clk);
        end
        check({tag, "_rbusy_lo"}, {31'b0, d1_rbusy}, 32'd0);
        check(tag, d1_rdata, exp);
    endtask

    initial begin
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        i0_addr = '0; i0_rstrb = 1'b0; d0_addr = '0; d0_wdata = '0; d0_wmask = '0;
        d0_wstrb = 1'b0; d0_rstrb = 1'b0;
        i1_addr = '0; i1_rstrb = 1'b0; d1_addr = '0; d1_wdata = '0; d1_wmask = '0;
        d1_wstrb = 1'b0; d1_rstrb = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_i0_rdata", i0_rdata, 32'h0);
        check("rst_d0_rdata", d0_rdata, 32'h0);
        check("rst_d0_flags", {28'b0, i0_rbusy, d0_rbusy, d0_wbusy, d0_err}, 32'h0);
        check("rst_d1_flags", {28'b0, i1_rbusy, d1_rbusy, d1_wbusy, d1_err}, 32'h0);
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        @(negedge clk);

        // preload words 0..3 through the zero-wait data port
        d0_write(32'h0, 32'd1, 4'hF);
        d0_write(32'h4, 32'd2, 4'hF);
        d0_write(32'h8, 32'd3, 4'hF);
        d0_write(32'hC, 32'd4, 4'hF);

        // back-to-back instruction reads with strobe held high
        i0_rstrb = 1'b1; i0_addr = 32'h0;
        @(negedge clk); check("t1_rd0", i0_rdata, 32'd1); check("t1_busy0", {31'b0, i0_rbusy}, 32'd0);
        i0_addr = 32'h4;
        @(negedge clk); check("t1_rd1", i0_rdata, 32'd2); check("t1_busy1", {31'b0, i0_rbusy}, 32'd0);
        i0_addr = 32'h8;
        @(negedge clk); check("t1_rd2", i0_rdata, 32'd3); check("t1_busy2", {31'b0, i0_rbusy}, 32'd0);
        i0_rstrb = 1'b0; i0_addr = 32'hC;
        @(negedge clk); check("t1_hold", i0_rdata, 32'd3);

        // byte-lane masked write
        d0_write(32'h10, 32'hAABBCCDD, 4'b1111);
        d0_write(32'h10, 32'h11111111, 4'b0010);
        d0_read("t2_masked", 32'h10, 32'hAABB11DD);

        // read/write collision and out-of-range write
        d0_addr = 32'h20; d0_wdata = 32'd5; d0_wmask = 4'hF; d0_wstrb = 1'b1; d0_rstrb = 1'b1;
        @(negedge clk);
        d0_wstrb = 1'b0; d0_rstrb = 1'b0;
        check("t4_coll_err", {31'b0, d0_err}, 32'd1);
        check("t4_coll_rdata", d0_rdata, 32'hAABB11DD);
        check("t4_coll_rbusy", {31'b0, d0_rbusy}, 32'd0);
        @(negedge clk);
        check("t4_err_pulse", {31'b0, d0_err}, 32'd0);
        d0_read("t4_coll_wr", 32'h20, 32'd5);
        d0_write(32'h0010_0000, 32'hDEADBEEF, 4'hF);
        check("t4_oor_werr", {31'b0, d0_err}, 32'd1);
        d0_read("t4_oor_nowr", 32'h0, 32'd1);
        d0_read("t4_oor_rd", 32'h0010_0000, 32'h0);
        check("t4_oor_rerr", {31'b0, d0_err}, 32'd1);

        // instruction read out of range returns zero, no error
        i0_addr = 32'h0010_0004; i0_rstrb = 1'b1;
        @(negedge clk);
        i0_rstrb = 1'b0;
        check("i_oor_rdata", i0_rdata, 32'h0);
        check("i_oor_noerr", {31'b0, d0_err}, 32'd0);

        // same-edge data write and instruction read of one word
        d0_write(32'h40, 32'h66, 4'hF);
        i0_addr = 32'h40; i0_rstrb = 1'b1;
        d0_addr = 32'h40; d0_wdata = 32'd7; d0_wmask = 4'hF; d0_wstrb = 1'b1;
        @(negedge clk);
        d0_wstrb = 1'b0;
        check("t6_rbw_old", i0_rdata, 32'h66);
        @(negedge clk);
        i0_rstrb = 1'b0;
        check("t6_rbw_new", i0_rdata, 32'd7);
        d0_read("t6_d_new", 32'h40, 32'd7);

        // wait-state data read, second strobe during wait ignored
        d1_write(32'h10, 32'h1234);
        d1_addr = 32'h10; d1_rstrb = 1'b1;
        @(negedge clk);
        d1_rstrb = 1'b0;
        check("t3_busy1", {31'b0, d1_rbusy}, 32'd1);
        @(negedge clk);
        check("t3_busy2", {31'b0, d1_rbusy}, 32'd1);
        d1_addr = 32'h0; d1_rstrb = 1'b1;
        @(negedge clk);
        d1_rstrb = 1'b0;
        check("t3_busy3", {31'b0, d1_rbusy}, 32'd1);
        check("t3_not_yet", d1_rdata, 32'h0);
        @(negedge clk);
        check("t3_busy4", {31'b0, d1_rbusy}, 32'd0);
        check("t3_rdata", d1_rdata, 32'h1234);
        @(negedge clk);
        check("t3_no_queue", {31'b0, d1_rbusy}, 32'd0);
        check("t3_hold", d1_rdata, 32'h1234);

        // one-cycle instruction wait
        i1_addr = 32'h10; i1_rstrb = 1'b1;
        @(negedge clk);
        i1_rstrb = 1'b0;
        check("iw_busy", {31'b0, i1_rbusy}, 32'd1);
        check("iw_not_yet", i1_rdata, 32'h0);
        @(negedge clk);
        check("iw_done", {31'b0, i1_rbusy}, 32'd0);
        check("iw_rdata", i1_rdata, 32'h1234);

        // reset in the middle of a waited write abandons it
        d1_write(32'h30, 32'h55);
        d1_addr = 32'h30; d1_wdata = 32'd9; d1_wmask = 4'hF; d1_wstrb = 1'b1;
        @(negedge clk);
        d1_wstrb = 1'b0;
        check("t5_wbusy1", {31'b0, d1_wbusy}, 32'd1);
        @(negedge clk);
        check("t5_wbusy2", {31'b0, d1_wbusy}, 32'd1);
        rst_n1 = 1'b0;
        #1;
        check("t5_rst_flags", {29'b0, d1_rbusy, d1_wbusy, d1_err}, 32'h0);
        check("t5_rst_rdata", d1_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n1 = 1'b1;
        @(negedge clk);
        d1_read("t5_old", 32'h30, 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
